// File: rtl/resonator_ddc_mul_arbiter_if.sv
// Operand/result bus between the DDC requesters and resonator_ddc_mul_arbiter.
// Requester i owns req_a[18*i +: 18], req_b[16*i +: 16], and bit i of the valid/ready/res_valid vectors.
interface resonator_ddc_mul_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*18-1:0] req_a;
    logic [NREQ*16-1:0] req_b;
    logic [NREQ-1:0]    res_valid;
    logic signed [33:0] res_data;
    logic [IDW-1:0]     res_id;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, res_valid, res_data, res_id
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, res_valid, res_data, res_id
    );
endinterface

// File: rtl/resonator_ddc_mul_arbiter.sv
// Round-robin share of one pipelined 18x16 signed multiplier among NREQ requesters.
// Optional per-requester grant counters are built when RESONATOR_DDC_MUL_ARB_STATS_EN is defined.
module resonator_ddc_mul_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int MUL_LAT = 4,
    parameter int CNTW    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       hold,
    resonator_ddc_mul_arbiter_if.slave bus,
    output logic                       mul_ce,
    output logic signed [17:0]         mul_din0,
    output logic signed [15:0]         mul_din1,
    input  logic signed [33:0]         mul_dout,
    output logic [NREQ*CNTW-1:0]       grant_cnt
);
    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     gnt_id;
    logic [IDW-1:0]     cand_id;
    logic [IDW:0]       cand;
    logic               gnt_found;
    logic               xfer;
    logic signed [17:0] sel_a;
    logic signed [15:0] sel_b;
    logic [MUL_LAT:0]   tag_v;
    logic [IDW-1:0]     tag_id [MUL_LAT+1];

    // Search from ptr upward with wrap; the first valid requester wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        cand      = '0;
        cand_id   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (32'(cand) >= NREQ)
                cand = cand - (IDW+1)'(NREQ);
            cand_id = cand[IDW-1:0];
            if (!gnt_found && bus.req_valid[cand_id]) begin
                gnt_found = 1'b1;
                gnt_id    = cand_id;
            end
        end
    end

    assign xfer   = gnt_found & ~hold;
    assign mul_ce = ~hold;

    always_comb begin
        bus.req_ready = '0;
        for (int unsigned i = 0; i < NREQ; i++)
            bus.req_ready[i] = xfer && (gnt_id == IDW'(i));
        sel_a = bus.req_a[18*gnt_id +: 18];
        sel_b = bus.req_b[16*gnt_id +: 16];
    end

    // Operand registers and tag pipe share the multiplier's ce so tags stay aligned with mul_dout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr      <= '0;
            mul_din0 <= '0;
            mul_din1 <= '0;
            tag_v    <= '0;
            for (int unsigned i = 0; i <= MUL_LAT; i++)
                tag_id[i] <= '0;
        end else if (!hold) begin
            if (xfer) begin
                mul_din0 <= sel_a;
                mul_din1 <= sel_b;
                ptr      <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
            end
            tag_v     <= {tag_v[MUL_LAT-1:0], xfer};
            tag_id[0] <= gnt_id;
            for (int unsigned i = 1; i <= MUL_LAT; i++)
                tag_id[i] <= tag_id[i-1];
        end
    end

    always_comb begin
        bus.res_valid = '0;
        for (int unsigned i = 0; i < NREQ; i++)
            bus.res_valid[i] = tag_v[MUL_LAT] && !hold && (tag_id[MUL_LAT] == IDW'(i));
    end

    assign bus.res_data = mul_dout;
    assign bus.res_id   = tag_id[MUL_LAT];

`ifdef RESONATOR_DDC_MUL_ARB_STATS_EN
    logic [CNTW-1:0] cnt [NREQ];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREQ; i++)
                cnt[i] <= '0;
        end else if (xfer) begin
            cnt[gnt_id] <= cnt[gnt_id] + 1'b1;
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int unsigned i = 0; i < NREQ; i++)
            grant_cnt[CNTW*i +: CNTW] = cnt[i];
    end
`else
    assign grant_cnt = '0;
`endif
endmodule

// File: tb/tb_resonator_ddc_mul_arbiter.sv
// Directed bench for resonator_ddc_mul_arbiter with a 4-stage ce-gated multiplier model.
module tb_resonator_ddc_mul_arbiter;
    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int MUL_LAT = 4;
    localparam int CNTW    = 32;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     hold = 1'b0;
    logic                     mul_ce;
    logic signed [17:0]       mul_din0;
    logic signed [15:0]       mul_din1;
    logic signed [33:0]       mul_dout;
    logic [NREQ*CNTW-1:0]     grant_cnt;
    logic signed [33:0]       mp [MUL_LAT];
    int                       vecs = 0;
    int                       errs = 0;

    resonator_ddc_mul_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    resonator_ddc_mul_arbiter #(
        .NREQ(NREQ), .IDW(IDW), .MUL_LAT(MUL_LAT), .CNTW(CNTW)
    ) dut (
        .clk(clk), .reset(reset), .hold(hold), .bus(bus),
        .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1),
        .mul_dout(mul_dout), .grant_cnt(grant_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mul_ce) begin
            mp[0] <= 34'(mul_din0) * 34'(mul_din1);
            for (int i = 1; i < MUL_LAT; i++)
                mp[i] <= mp[i-1];
        end
    end
    assign mul_dout = mp[MUL_LAT-1];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        hold = 1'b0;
        bus.req_valid = '0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vecs++; if (bus.req_ready !== 4'b0000) begin errs++; $display("FAIL rst_ready: got %b expected 0000", bus.req_ready); end
        vecs++; if (bus.res_valid !== 4'b0000) begin errs++; $display("FAIL rst_res_valid: got %b expected 0000", bus.res_valid); end
        vecs++; if (mul_din0 !== 18'sd0) begin errs++; $display("FAIL rst_din0: got %0d expected 0", mul_din0); end
        vecs++; if (mul_din1 !== 16'sd0) begin errs++; $display("FAIL rst_din1: got %0d expected 0", mul_din1); end
        vecs++; if (grant_cnt !== '0) begin errs++; $display("FAIL rst_grant_cnt: got %h expected 0", grant_cnt); end
        next_cycle();
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            vecs++; if (bus.req_ready !== 4'b0000) begin errs++; $display("FAIL idle_ready c=%0d: got %b expected 0000", c, bus.req_ready); end
            vecs++; if (bus.res_valid !== 4'b0000) begin errs++; $display("FAIL idle_res_valid c=%0d: got %b expected 0000", c, bus.res_valid); end
            next_cycle();
        end
    endtask

    task automatic test_single();
        logic signed [33:0] exp_d;
        logic [3:0]         exp_v;
        exp_d = -34'sd4294836224;
        bus.req_a[0 +: 18] = -18'sd131072;
        bus.req_b[0 +: 16] = 16'sd32767;
        bus.req_valid = 4'b0001;
        @(negedge clk);
        vecs++; if (bus.req_ready !== 4'b0001) begin errs++; $display("FAIL single_ready: got %b expected 0001", bus.req_ready); end
        next_cycle();
        bus.req_valid = '0;
        for (int k = 1; k <= 8; k++) begin
            exp_v = (k == 5) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            vecs++; if (bus.res_valid !== exp_v) begin errs++; $display("FAIL single_res_valid k=%0d: got %b expected %b", k, bus.res_valid, exp_v); end
            if (k == 5) begin
                vecs++; if (bus.res_data !== exp_d) begin errs++; $display("FAIL single_res_data: got %0d expected %0d", bus.res_data, exp_d); end
                vecs++; if (bus.res_id !== 2'd0) begin errs++; $display("FAIL single_res_id: got %0d expected 0", bus.res_id); end
            end
            next_cycle();
        end
    endtask

    task automatic test_all4();
        logic [3:0]         exp_r;
        logic [3:0]         exp_v;
        logic signed [33:0] exp_d;
        int                 g;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[18*i +: 18] = 18'(i + 1);
            bus.req_b[16*i +: 16] = 16'sd10;
        end
        for (int c = 0; c < 20; c++) begin
            bus.req_valid = (c < 12) ? 4'b1111 : 4'b0000;
            exp_r = (c < 12) ? (4'b0001 << (c % 4)) : 4'b0000;
            g = (c - 5) % 4;
            exp_v = (c >= 5 && c < 17) ? (4'b0001 << g) : 4'b0000;
            exp_d = 34'((g + 1) * 10);
            @(negedge clk);
            vecs++; if (bus.req_ready !== exp_r) begin errs++; $display("FAIL all4_ready c=%0d: got %b expected %b", c, bus.req_ready, exp_r); end
            vecs++; if (bus.res_valid !== exp_v) begin errs++; $display("FAIL all4_res_valid c=%0d: got %b expected %b", c, bus.res_valid, exp_v); end
            if (c >= 5 && c < 17) begin
                vecs++; if (bus.res_data !== exp_d) begin errs++; $display("FAIL all4_res_data c=%0d: got %0d expected %0d", c, bus.res_data, exp_d); end
                vecs++; if (bus.res_id !== 2'(g)) begin errs++; $display("FAIL all4_res_id c=%0d: got %0d expected %0d", c, bus.res_id, g); end
            end
            next_cycle();
        end
    endtask

    task automatic test_lone();
        logic [3:0]         exp_r;
        logic [3:0]         exp_v;
        logic signed [33:0] exp_d;
        do_reset();
        bus.req_b[32 +: 16] = -16'sd3;
        for (int c = 0; c < 10; c++) begin
            bus.req_valid = (c < 4) ? 4'b0100 : 4'b0000;
            bus.req_a[36 +: 18] = 18'(1000 * (c + 1));
            exp_r = (c < 4) ? 4'b0100 : 4'b0000;
            exp_v = (c >= 5 && c <= 8) ? 4'b0100 : 4'b0000;
            exp_d = 34'(-3000 * (c - 4));
            @(negedge clk);
            vecs++; if (bus.req_ready !== exp_r) begin errs++; $display("FAIL lone_ready c=%0d: got %b expected %b", c, bus.req_ready, exp_r); end
            vecs++; if (bus.res_valid !== exp_v) begin errs++; $display("FAIL lone_res_valid c=%0d: got %b expected %b", c, bus.res_valid, exp_v); end
            if (c >= 5 && c <= 8) begin
                vecs++; if (bus.res_data !== exp_d) begin errs++; $display("FAIL lone_res_data c=%0d: got %0d expected %0d", c, bus.res_data, exp_d); end
            end
            next_cycle();
        end
    endtask

    task automatic test_hold();
        logic [3:0]         exp_r;
        logic [3:0]         exp_v;
        logic signed [33:0] exp_d;
        int                 idx;
        int                 j;
        int                 g;
        do_reset();
        bus.req_a[18 +: 18] = 18'sd5;
        bus.req_b[16 +: 16] = 16'sd3;
        bus.req_a[54 +: 18] = -18'sd7;
        bus.req_b[48 +: 16] = 16'sd100;
        for (int c = 0; c < 16; c++) begin
            hold = (c >= 6 && c <= 8);
            bus.req_valid = (c <= 9) ? 4'b1010 : 4'b0000;
            idx = hold ? -1 : ((c < 6) ? c : c - 3);
            exp_r = (!hold && c <= 9) ? (((idx % 2) == 0) ? 4'b0010 : 4'b1000) : 4'b0000;
            j = idx - 5;
            g = ((j % 2) == 0) ? 1 : 3;
            exp_v = (!hold && j >= 0 && j <= 6) ? (4'b0001 << g) : 4'b0000;
            exp_d = (g == 1) ? 34'sd15 : -34'sd700;
            @(negedge clk);
            vecs++; if (bus.req_ready !== exp_r) begin errs++; $display("FAIL hold_ready c=%0d: got %b expected %b", c, bus.req_ready, exp_r); end
            vecs++; if (bus.res_valid !== exp_v) begin errs++; $display("FAIL hold_res_valid c=%0d: got %b expected %b", c, bus.res_valid, exp_v); end
            if (!hold && j >= 0 && j <= 6) begin
                vecs++; if (bus.res_data !== exp_d) begin errs++; $display("FAIL hold_res_data c=%0d: got %0d expected %0d", c, bus.res_data, exp_d); end
                vecs++; if (bus.res_id !== 2'(g)) begin errs++; $display("FAIL hold_res_id c=%0d: got %0d expected %0d", c, bus.res_id, g); end
            end
            vecs++; if (mul_ce !== !hold) begin errs++; $display("FAIL hold_mul_ce c=%0d: got %b expected %b", c, mul_ce, !hold); end
            next_cycle();
        end
        hold = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.req_a[0 +: 18] = 18'sd9;
        bus.req_a[36 +: 18] = 18'sd11;
        bus.req_b[0 +: 16] = 16'sd2;
        bus.req_b[32 +: 16] = 16'sd2;
        for (int c = 0; c < 16; c++) begin
            bus.req_valid = (c < 3) ? 4'b0101 : 4'b0000;
            reset = (c == 4);
            @(negedge clk);
            if (c == 0) begin
                vecs++; if (bus.req_ready !== 4'b0001) begin errs++; $display("FAIL rmid_ready: got %b expected 0001", bus.req_ready); end
            end
            if (c == 4) begin
                vecs++; if (mul_din0 !== 18'sd0) begin errs++; $display("FAIL rmid_din0: got %0d expected 0", mul_din0); end
            end
            vecs++; if (bus.res_valid !== 4'b0000) begin errs++; $display("FAIL rmid_res_valid c=%0d: got %b expected 0000", c, bus.res_valid); end
            next_cycle();
        end
        reset = 1'b0;
    endtask

    task automatic test_stats();
        logic [CNTW-1:0] exp_c;
`ifdef RESONATOR_DDC_MUL_ARB_STATS_EN
        exp_c = 32'd25;
`else
        exp_c = 32'd0;
`endif
        do_reset();
        bus.req_valid = 4'b1111;
        for (int c = 0; c < 100; c++)
            next_cycle();
        bus.req_valid = 4'b0000;
        next_cycle();
        for (int i = 0; i < NREQ; i++) begin
            vecs++; if (grant_cnt[CNTW*i +: CNTW] !== exp_c) begin errs++; $display("FAIL stats_cnt%0d: got %0d expected %0d", i, grant_cnt[CNTW*i +: CNTW], exp_c); end
        end
        do_reset();
        @(negedge clk);
        vecs++; if (grant_cnt !== '0) begin errs++; $display("FAIL stats_clear: got %h expected 0", grant_cnt); end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        test_reset();
        test_single();
        test_all4();
        test_lone();
        test_hold();
        test_reset_mid();
        test_stats();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
